// File: rtl/mul_pkg.sv
// Shared types and sizing for the sequential shift-add multiplier.
// The widths match the 16-bit carry-look-ahead adder.
package mul_pkg;

  localparam int MUL_W     = 16;
  localparam int MUL_ITER  = 16;
  localparam int MUL_CNT_W = 5;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

endpackage

// File: rtl/shift_add_multiplier_16bit_if.sv
// Bundles the start/operand request and the busy/done/product response.
// The master drives the request side and the slave drives the response side.
interface shift_add_multiplier_16bit_if;
  import mul_pkg::*;

  logic                 start;
  logic [MUL_W-1:0]     a;
  logic [MUL_W-1:0]     b;
  logic                 busy;
  logic                 done;
  logic [2*MUL_W-1:0]   product;

  modport master (output start, a, b, input busy, done, product);
  modport slave  (input start, a, b, output busy, done, product);

endinterface

// File: rtl/shift_add_multiplier_16bit_cla.sv
// 16-bit carry-look-ahead adder built from four 4-bit look-ahead groups.
// Group carries ripple between the groups.
module Carry_Look_Ahead_Adder_16bit (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);

  logic [15:0] g;
  logic [15:0] p;
  logic [16:0] c;

  // Within each group, every carry comes straight from g/p and the group carry-in.
  always_comb begin
    g = a & b;
    p = a ^ b;
    c = '0;
    c[0] = cin;
    for (int k = 0; k < 4; k++) begin
      c[4*k+1] = g[4*k] | (p[4*k] & c[4*k]);
      c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k])
               | (p[4*k+1] & p[4*k] & c[4*k]);
      c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1])
               | (p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+2] & p[4*k+1] & p[4*k] & c[4*k]);
      c[4*k+4] = g[4*k+3] | (p[4*k+3] & g[4*k+2])
               | (p[4*k+3] & p[4*k+2] & g[4*k+1])
               | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+3] & p[4*k+2] & p[4*k+1] & p[4*k] & c[4*k]);
    end
    sum  = p ^ c[15:0];
    cout = c[16];
  end

endmodule

// File: rtl/shift_add_multiplier_16bit.sv
// Sequential unsigned 16x16->32 shift-add multiplier that performs one adder pass per clock.
// Defining MUL_EARLY_TERM_EN ends RUN as soon as no multiplier bits remain to be consumed.
module shift_add_multiplier_16bit
  import mul_pkg::*;
(
  input logic                     clk,
  input logic                     rst,
  shift_add_multiplier_16bit_if.slave bus
);

  state_t               state;
  state_t               state_nxt;
  logic [MUL_W-1:0]     mcand;
  logic [MUL_W-1:0]     acc;
  logic [MUL_W-1:0]     q;
  logic [MUL_CNT_W-1:0] cnt;
  logic [2*MUL_W-1:0]   product;

  logic [MUL_W-1:0]     add_b;
  logic [MUL_W-1:0]     sum;
  logic                 cout;
  logic [MUL_W-1:0]     acc_nxt;
  logic [MUL_W-1:0]     q_nxt;
  logic [2*MUL_W-1:0]   result;
  logic                 last_iter;
  logic                 load;
  logic                 zero_start;

  assign add_b   = q[0] ? mcand : '0;
  assign acc_nxt = {cout, sum[MUL_W-1:1]};
  assign q_nxt   = {sum[0], q[MUL_W-1:1]};
  assign load    = bus.start && (state != RUN);

  Carry_Look_Ahead_Adder_16bit u_cla (
    .a    (acc),
    .b    (add_b),
    .cin  (1'b0),
    .sum  (sum),
    .cout (cout)
  );

`ifdef MUL_EARLY_TERM_EN
  logic [MUL_CNT_W-1:0] remain;
  logic [MUL_W-1:0]     pending_mask;

  // After this pass, q[15-cnt:1] still holds the unconsumed multiplier bits.
  assign remain       = 5'd15 - cnt;
  assign pending_mask = (16'd1 << remain) - 16'd1;
  assign last_iter    = ((q >> 1) & pending_mask) == '0;
  assign result       = {acc_nxt, q_nxt} >> remain;
  assign zero_start   = load && (bus.b == '0);
`else
  assign last_iter    = (cnt == 5'(MUL_ITER - 1));
  assign result       = {acc_nxt, q_nxt};
  assign zero_start   = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (bus.start) state_nxt = zero_start ? DONE : RUN;
      RUN:  if (last_iter) state_nxt = DONE;
      DONE: begin
        if (bus.start) state_nxt = zero_start ? DONE : RUN;
        else           state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.busy    = (state == RUN);
    bus.done    = (state == DONE);
    bus.product = product;
  end

  // A new start is accepted in IDLE or DONE. RUN ignores start and the operand inputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand   <= '0;
      acc     <= '0;
      q       <= '0;
      cnt     <= '0;
      product <= '0;
    end else begin
      if (load) begin
        mcand <= bus.a;
        q     <= bus.b;
        acc   <= '0;
        cnt   <= '0;
      end else if (state == RUN) begin
        acc <= acc_nxt;
        q   <= q_nxt;
        cnt <= cnt + 5'd1;
      end
      if (state == RUN && last_iter) product <= result;
      else if (zero_start)           product <= '0;
    end
  end

endmodule

// File: tb/tb_shift_add_multiplier_16bit.sv
// Self-checking bench for shift_add_multiplier_16bit.
// Uses directed and random operands against an arithmetic reference model.
module tb_shift_add_multiplier_16bit;
  import mul_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   compared   = 0;
  int   mismatched = 0;

  always #5 clk = ~clk;

  shift_add_multiplier_16bit_if bus ();

  shift_add_multiplier_16bit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Number of RUN cycles the operation should take for multiplier ib.
  function automatic int expRun(input logic [15:0] ib);
`ifdef MUL_EARLY_TERM_EN
    for (int i = 15; i >= 0; i--) if (ib[i]) return i + 1;
    return 0;
`else
    return MUL_ITER + 0 * int'(ib[0]);
`endif
  endfunction

  task automatic applyStimulus(input logic [15:0] ia, input logic [15:0] ib);
    bus.start = 1'b1;
    bus.a     = ia;
    bus.b     = ib;
    tick();
    bus.start = 1'b0;
  endtask

  // Called in cycle 1 of an operation. Optionally launches the next operation in the DONE cycle.
  task automatic monitor(input logic [15:0] ia, input logic [15:0] ib, input bit noise,
                         input bit chain, input logic [15:0] ca, input logic [15:0] cb);
    int          runlen;
    logic [31:0] exp_prod;
    logic        exp_busy;
    logic        exp_done;
    runlen   = expRun(ib);
    exp_prod = {16'd0, ia} * {16'd0, ib};
    bus.start = 1'b0;
    for (int cyc = 1; cyc <= runlen + 1; cyc++) begin
      exp_busy = (cyc <= runlen);
      exp_done = (cyc == runlen + 1);
      checkOutput($sformatf("busy c%0d", cyc), {31'd0, bus.busy}, {31'd0, exp_busy});
      checkOutput($sformatf("done c%0d", cyc), {31'd0, bus.done}, {31'd0, exp_done});
      if (exp_done)
        checkOutput($sformatf("product %04h*%04h", ia, ib), bus.product, exp_prod);
      if (noise && exp_busy) begin
        bus.a     = 16'($urandom);
        bus.b     = 16'($urandom);
        bus.start = (cyc == 5);
      end
      if (exp_done) begin
        bus.start = chain;
        bus.a     = ca;
        bus.b     = cb;
      end
      tick();
    end
    if (!chain) begin
      checkOutput("idle busy", {31'd0, bus.busy}, 32'd0);
      checkOutput("idle done", {31'd0, bus.done}, 32'd0);
      checkOutput("product hold", bus.product, exp_prod);
    end
  endtask

  task automatic runOp(input logic [15:0] ia, input logic [15:0] ib, input bit noise);
    applyStimulus(ia, ib);
    monitor(ia, ib, noise, 1'b0, 16'd0, 16'd0);
  endtask

  initial begin
    logic [15:0] ra;
    logic [15:0] rb;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    repeat (2) tick();
    checkOutput("reset busy", {31'd0, bus.busy}, 32'd0);
    checkOutput("reset done", {31'd0, bus.done}, 32'd0);
    checkOutput("reset product", bus.product, 32'd0);
    rst = 1'b0;
    tick();

    runOp(16'hFFFF, 16'hFFFF, 1'b0);
    runOp(16'h0003, 16'h0005, 1'b0);
    runOp(16'h1234, 16'h0000, 1'b0);
    runOp(16'h0002, 16'h0007, 1'b1);

    // Back-to-back: second start lands in the DONE cycle of the first operation.
    applyStimulus(16'h0100, 16'h0100);
    monitor(16'h0100, 16'h0100, 1'b0, 1'b1, 16'hFFFF, 16'h0002);
    monitor(16'hFFFF, 16'h0002, 1'b0, 1'b0, 16'd0, 16'd0);

    // Asynchronous reset in the middle of a run.
    applyStimulus(16'hBEEF, 16'h8001);
    repeat (7) tick();
    #2 rst = 1'b1;
    #1;
    checkOutput("midrun rst busy", {31'd0, bus.busy}, 32'd0);
    checkOutput("midrun rst done", {31'd0, bus.done}, 32'd0);
    checkOutput("midrun rst product", bus.product, 32'd0);
    tick();
    rst = 1'b0;
    tick();
    runOp(16'hA5A5, 16'h5A5A, 1'b0);

    for (int i = 0; i < 20; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      if (i % 4 == 1) rb = rb >> (i % 16);
      runOp(ra, rb, (i % 3) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
